// File: rtl/scan_sel_pkg.sv
// ----------------------------------------------------------------------------
// scan_sel_pkg
// Shared types and constants for the scan select sequencer.
//   state_e  : sequencer state (IDLE / DWELL)
//   SEL_W    : width of the channel select
//   NUM_CH   : number of decoder channels
//   CH_FIRST : first channel of an unmasked sweep
//   CH_LAST  : last channel of an unmasked sweep
// ----------------------------------------------------------------------------
package scan_sel_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_e;

    localparam int               SEL_W    = 2;
    localparam int               NUM_CH   = 4;
    localparam logic [SEL_W-1:0] CH_FIRST = 2'd0;
    localparam logic [SEL_W-1:0] CH_LAST  = 2'd3;

endpackage

// File: rtl/scan_sel_sequencer_dwell_counter.sv
// ----------------------------------------------------------------------------
// dwell_counter
// Load / decrement down-counter with a zero flag. Load has priority over
// decrement; decrement saturates at zero so the counter never wraps.
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val on the next edge
//   load_val in   value to load
//   dec      in   decrement by one on the next edge
//   zero     out  count is zero
// ----------------------------------------------------------------------------
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/scan_sel_sequencer.sv
// ----------------------------------------------------------------------------
// scan_sel_sequencer
// Steps a 2-bit channel select through the decoder channels, holding each one
// for dwell_len+1 cycles. Sweeps are single-shot or continuous and are started
// by a start pulse in IDLE; stop aborts a sweep at any time.
//
// Optional feature macro: SCAN_SKIP_MASK_EN
//   When defined, a ch_mask port selects which channels take part in a sweep;
//   masked channels are skipped entirely and an all-zero mask refuses start.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a sweep (IDLE only)
//   stop       in   abort the current sweep, highest priority
//   continuous in   latched at start: wrap forever when 1
//   dwell_len  in   latched at start: per-channel hold is dwell_len+1 cycles
//   ch_mask    in   (SCAN_SKIP_MASK_EN) latched at start, bit i enables ch i
//   sel        out  channel select to the decoder
//   sel_valid  out  sel is live
//   busy       out  sweep in progress
//   ch_step    out  pulse on the first cycle of each new channel
//   done       out  pulse on the cycle after the last channel finishes
// ----------------------------------------------------------------------------
module scan_sel_sequencer
    import scan_sel_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [DWELL_W-1:0] dwell_len,
`ifdef SCAN_SKIP_MASK_EN
    input  logic [NUM_CH-1:0]  ch_mask,
`endif
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               ch_step,
    output logic               done
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               ch_step_q, ch_step_d;
    logic               done_q, done_d;
    logic               cont_q, cont_d;
    logic [DWELL_W-1:0] dwell_len_q, dwell_len_d;

    logic               cnt_load;
    logic [DWELL_W-1:0] cnt_load_val;
    logic               cnt_dec;
    logic               cnt_zero;

    // Channel ordering for the current sweep, and the start qualifiers
    logic [SEL_W-1:0]   first_ch;
    logic [SEL_W-1:0]   last_ch;
    logic [SEL_W-1:0]   next_ch;
    logic [SEL_W-1:0]   start_ch;
    logic               start_ok;

`ifdef SCAN_SKIP_MASK_EN
    logic [NUM_CH-1:0]  mask_q, mask_d;

    function automatic logic [SEL_W-1:0] mask_first(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] f;
        f = CH_FIRST;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) f = SEL_W'(i);
        end
        return f;
    endfunction

    function automatic logic [SEL_W-1:0] mask_last(input logic [NUM_CH-1:0] m);
        logic [SEL_W-1:0] l;
        l = CH_LAST;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) l = SEL_W'(i);
        end
        return l;
    endfunction

    // Next enabled channel strictly above cur; only consulted when cur is
    // not the last enabled channel, so a higher set bit always exists.
    function automatic logic [SEL_W-1:0] mask_next(input logic [NUM_CH-1:0] m,
                                                  input logic [SEL_W-1:0]  cur);
        logic [SEL_W-1:0] n;
        n = cur;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) n = SEL_W'(i);
        end
        return n;
    endfunction

    always_comb begin
        first_ch = mask_first(mask_q);
        last_ch  = mask_last(mask_q);
        next_ch  = mask_next(mask_q, sel_q);
        start_ch = mask_first(ch_mask);
        start_ok = (ch_mask != '0);
    end
`else
    always_comb begin
        first_ch = CH_FIRST;
        last_ch  = CH_LAST;
        next_ch  = sel_q + 1'b1;
        start_ch = CH_FIRST;
        start_ok = 1'b1;
    end
`endif

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State, registered outputs and latched configuration
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ch_step_q   <= 1'b0;
            done_q      <= 1'b0;
            cont_q      <= 1'b0;
            dwell_len_q <= '0;
`ifdef SCAN_SKIP_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ch_step_q   <= ch_step_d;
            done_q      <= done_d;
            cont_q      <= cont_d;
            dwell_len_q <= dwell_len_d;
`ifdef SCAN_SKIP_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Next-state logic; stop wins over a same-cycle counter expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && !stop && start_ok) state_d = DWELL;
            end
            DWELL: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_zero && (sel_q == last_ch) && !cont_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        sel_d        = sel_q;
        ch_step_d    = 1'b0;
        done_d       = 1'b0;
        cont_d       = cont_q;
        dwell_len_d  = dwell_len_q;
`ifdef SCAN_SKIP_MASK_EN
        mask_d       = mask_q;
`endif
        cnt_load     = 1'b0;
        cnt_load_val = dwell_len_q;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop && start_ok) begin
                    sel_d        = start_ch;
                    cont_d       = continuous;
                    dwell_len_d  = dwell_len;
`ifdef SCAN_SKIP_MASK_EN
                    mask_d       = ch_mask;
`endif
                    // Load straight from the port: the latched copy is not
                    // valid until the next edge.
                    cnt_load     = 1'b1;
                    cnt_load_val = dwell_len;
                end
            end
            DWELL: begin
                if (!stop) begin
                    if (!cnt_zero) begin
                        cnt_dec = 1'b1;
                    end else if (sel_q != last_ch) begin
                        sel_d     = next_ch;
                        cnt_load  = 1'b1;
                        ch_step_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (cont_q) begin
                            sel_d     = first_ch;
                            cnt_load  = 1'b1;
                            ch_step_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign sel       = sel_q;
    assign sel_valid = (state_q == DWELL);
    assign busy      = (state_q == DWELL);
    assign ch_step   = ch_step_q;
    assign done      = done_q;

endmodule

// File: tb/tb_scan_sel_sequencer.sv
module tb_scan_sel_sequencer;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               continuous;
    logic [DWELL_W-1:0] dwell_len;
    logic [3:0]         ch_mask;
    logic [1:0]         sel;
    logic               sel_valid;
    logic               busy;
    logic               ch_step;
    logic               done;

    always #5 clk = ~clk;

    scan_sel_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .dwell_len  (dwell_len),
`ifdef SCAN_SKIP_MASK_EN
        .ch_mask    (ch_mask),
`endif
        .sel        (sel),
        .sel_valid  (sel_valid),
        .busy       (busy),
        .ch_step    (ch_step),
        .done       (done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    // Reference model: a sweep is the ordered list of enabled channels; each
    // entry is shown for dwell+1 cycles, tracked as time spent on the entry.
    bit         m_active;
    int         m_list[$];
    int         m_pos;
    int         m_age;
    int         m_dwell;
    bit         m_cont;
    logic [1:0] exp_sel;
    logic       exp_step;
    logic       exp_done;

    task automatic model_step();
        exp_step = 1'b0;
        exp_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            exp_sel  = 2'd0;
        end else if (m_active) begin
            if (stop) begin
                m_active = 1'b0;
            end else if (m_age == m_dwell) begin
                m_age = 0;
                if (m_pos == m_list.size() - 1) begin
                    exp_done = 1'b1;
                    if (m_cont) begin
                        m_pos    = 0;
                        exp_sel  = 2'(m_list[0]);
                        exp_step = 1'b1;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_pos    = m_pos + 1;
                    exp_sel  = 2'(m_list[m_pos]);
                    exp_step = 1'b1;
                end
            end else begin
                m_age = m_age + 1;
            end
        end else if (start && !stop && (ch_mask != 4'd0)) begin
            m_list.delete();
            for (int c = 0; c < 4; c++) if (ch_mask[c]) m_list.push_back(c);
            m_active = 1'b1;
            m_pos    = 0;
            m_age    = 0;
            m_dwell  = int'(dwell_len);
            m_cont   = continuous;
            exp_sel  = 2'(m_list[0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_eq("sel",       32'(sel),       32'(exp_sel));
        check_eq("sel_valid", 32'(sel_valid), 32'(m_active));
        check_eq("busy",      32'(busy),      32'(m_active));
        check_eq("ch_step",   32'(ch_step),   32'(exp_step));
        check_eq("done",      32'(done),      32'(exp_done));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic [DWELL_W-1:0] dl, input logic cont, input logic [3:0] mask);
        dwell_len  = dl;
        continuous = cont;
        ch_mask    = mask;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        // Scramble the config inputs; the running sweep must ignore them
        dwell_len  = DWELL_W'($urandom);
        continuous = 1'($urandom);
`ifdef SCAN_SKIP_MASK_EN
        ch_mask    = 4'($urandom);
`endif
    endtask

    task automatic run_until_sel(input logic [1:0] s, input int budget);
        int k;
        k = 0;
        while (!(m_active && exp_sel == s) && k < budget) begin
            tick();
            k++;
        end
        if (k >= budget) check_eq("wait_sel_timeout", 32'(k), 32'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        dwell_len = '0; ch_mask = 4'hF;
        m_active = 1'b0; exp_sel = 2'd0; exp_step = 1'b0; exp_done = 1'b0;
        m_pos = 0; m_age = 0; m_dwell = 0; m_cont = 1'b0;
        @(negedge clk);

        // Reset then idle
        ticks(2);
        rst = 1'b0;
        ticks(6);

        // Single-shot sweep, dwell 3
        pulse_start(8'd3, 1'b0, 4'hF);
        ticks(20);

        // Continuous, dwell 0, stop while sel=2
        pulse_start(8'd0, 1'b1, 4'hF);
        ticks(9);
        run_until_sel(2'd2, 8);
        stop = 1'b1; tick(); stop = 1'b0;
        ticks(4);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        ticks(3);

        // start pulsed mid-sweep
        pulse_start(8'd5, 1'b0, 4'hF);
        ticks(3);
        dwell_len = 8'd1; start = 1'b1; tick(); start = 1'b0;
        ticks(26);

`ifdef SCAN_SKIP_MASK_EN
        pulse_start(8'd1, 1'b0, 4'b1010);
        ticks(8);
        pulse_start(8'd2, 1'b0, 4'b0000);
        ticks(4);
        pulse_start(8'd1, 1'b1, 4'b0100);
        ticks(10);
        stop = 1'b1; tick(); stop = 1'b0;
        ticks(3);
`endif

        // Reset mid-sweep while sel=1, then restart
        pulse_start(8'd3, 1'b0, 4'hF);
        run_until_sel(2'd1, 12);
        rst = 1'b1; tick(); rst = 1'b0;
        ticks(2);
        pulse_start(8'd2, 1'b0, 4'hF);
        ticks(14);

        // Maximum dwell: 256 cycles per channel
        pulse_start(8'hFF, 1'b0, 4'hF);
        ticks(1030);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            continuous = 1'($urandom);
            dwell_len  = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom_range(0, 40))
                                                     : DWELL_W'($urandom_range(0, 4));
`ifdef SCAN_SKIP_MASK_EN
            ch_mask = 4'($urandom);
`endif
            tick();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
